// File: rtl/matrix_result_collector_if.sv
// Result-collector bus: multiplier result capture on one side, C-matrix element readout on the other.
interface matrix_result_collector_if #(
  parameter int DW = 17,
  parameter int IW = 2
);
  logic signed [DW-1:0] in_data;
  logic                 in_strobe;
  logic signed [DW-1:0] c_data;
  logic [IW-1:0]        c_idx;
  logic                 c_last;
  logic                 c_valid;
  logic                 c_ready;
  logic                 ovf;
  logic                 clr_ovf;

  modport master (
    output in_data, in_strobe, c_ready, clr_ovf,
    input  c_data, c_idx, c_last, c_valid, ovf
  );

  modport slave (
    input  in_data, in_strobe, c_ready, clr_ovf,
    output c_data, c_idx, c_last, c_valid, ovf
  );
endinterface

// File: rtl/matrix_result_collector.sv
// Collects strobed multiplier results into 2x2 C matrices in a ping-pong pair of banks
// and drains them element by element over a valid/ready port.
module matrix_result_collector #(
  parameter int DW     = 17,
  parameter int N_ELEM = 4,
  parameter int PERIOD = 5,
  localparam int IW    = $clog2(N_ELEM)
) (
  input  logic                      clk,
  input  logic                      rst,
  matrix_result_collector_if.slave  bus
);

  logic signed [DW-1:0] mem [2][N_ELEM];

  logic [2:0]    phase;
  logic          strobe_q;
  logic          cap;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          wr_bank;
  logic          rd_bank;
  logic          dropping;
  logic [1:0]    bank_full;
  logic          ovf;

  logic first_wr, drop_now, drop_eff, wr_last;
  logic c_valid, rd_fire, rd_last;

  // IN_STROBE is a level: capture on its rising edge, then every PERIOD cycles while high
  assign cap      = bus.in_strobe & (~strobe_q | (phase == 3'(PERIOD - 1)));
  assign first_wr = (wr_idx == '0);
  assign drop_now = cap & first_wr & bank_full[wr_bank];
  assign drop_eff = first_wr ? bank_full[wr_bank] : dropping;
  assign wr_last  = (wr_idx == IW'(N_ELEM - 1));

  assign c_valid  = bank_full[rd_bank];
  assign rd_fire  = c_valid & bus.c_ready;
  assign rd_last  = (rd_idx == IW'(N_ELEM - 1));

  assign bus.c_valid = c_valid;
  assign bus.c_data  = c_valid ? mem[rd_bank][rd_idx] : '0;
  assign bus.c_idx   = rd_idx;
  assign bus.c_last  = c_valid & rd_last;
  assign bus.ovf     = ovf;

  always_ff @(posedge clk) begin
    if (cap & ~drop_eff) mem[wr_bank][wr_idx] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      strobe_q  <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      dropping  <= 1'b0;
      bank_full <= '0;
      ovf       <= 1'b0;
    end else begin
      strobe_q <= bus.in_strobe;
      phase    <= (cap | ~bus.in_strobe) ? 3'd0 : phase + 3'd1;

      // Read side frees a bank; it never targets the bank currently being filled
      if (rd_fire) begin
        if (rd_last) begin
          rd_idx             <= '0;
          bank_full[rd_bank] <= 1'b0;
          rd_bank            <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end

      if (cap) begin
        if (wr_last) begin
          wr_idx   <= '0;
          dropping <= 1'b0;
          if (!drop_eff) begin
            bank_full[wr_bank] <= 1'b1;
            wr_bank            <= ~wr_bank;
          end
        end else begin
          wr_idx   <= wr_idx + 1'b1;
          dropping <= drop_eff;
        end
      end else if (!bus.in_strobe) begin
        // strobe dropped mid-matrix: discard the partial matrix
        wr_idx   <= '0;
        dropping <= 1'b0;
      end

      if (drop_now)         ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_result_collector.sv
// Randomised scoreboard bench for matrix_result_collector against a queue/count reference model.
module tb_matrix_result_collector;
  localparam int DW = 17;
  localparam int N  = 4;
  localparam int P  = 5;

  typedef logic signed [DW-1:0] dat_t;
  typedef struct {
    dat_t d;
    int   idx;
    bit   last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_result_collector_if #(.DW(DW), .IW(2)) bus ();

  matrix_result_collector #(.DW(DW), .N_ELEM(N), .PERIOD(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: matrices held = count of full banks; drops decided by that count
  beat_t exp_q[$];
  dat_t  m_part[$];
  int    m_full, m_rd, m_cnt, m_hi;
  bit    m_prev, m_drop, m_ovf, m_rst;

  always @(posedge clk) begin
    bit cap, ovf_set, rd_ok;
    if (rst) begin
      m_full = 0; m_rd = 0; m_cnt = 0; m_hi = 0;
      m_prev = 0; m_drop = 0; m_ovf = 0; m_rst = 1;
      m_part.delete();
      exp_q.delete();
    end else begin
      m_rst   = 0;
      rd_ok   = (m_full > 0) && bus.c_ready;
      cap     = 0;
      ovf_set = 0;
      if (bus.in_strobe) begin
        m_hi = m_prev ? m_hi + 1 : 0;
        cap  = (m_hi % P) == 0;
      end
      if (cap) begin
        if (m_cnt == 0) begin
          m_drop  = (m_full == 2);
          ovf_set = m_drop;
        end
        if (!m_drop) m_part.push_back(bus.in_data);
        m_cnt++;
        if (m_cnt == N) begin
          if (!m_drop) begin
            m_full++;
            for (int i = 0; i < N; i++) exp_q.push_back('{m_part[i], i, i == N - 1});
          end
          m_cnt = 0;
          m_drop = 0;
          m_part.delete();
        end
      end else if (!bus.in_strobe) begin
        m_cnt = 0;
        m_drop = 0;
        m_part.delete();
      end
      if (rd_ok) begin
        m_rd++;
        if (m_rd == N) begin
          m_rd = 0;
          m_full--;
        end
      end
      if (ovf_set) m_ovf = 1;
      else if (bus.clr_ovf) m_ovf = 0;
      m_prev = bus.in_strobe;
    end
  end

  // Monitor: owns all comparisons and counters
  int   n_chk = 0;
  int   n_fail = 0;
  int   to_cnt = 0;
  int   to_seen = 0;
  bit   done_req = 0;
  bit   done_ack = 0;
  bit   hold_prev = 0;
  dat_t hold_d;
  int   hold_i;

  function automatic void check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      check("c_valid", bus.c_valid, m_full > 0);
      check("ovf", bus.ovf, m_ovf);
      if (m_rst) begin
        check("rst_c_data", bus.c_data, 0);
        check("rst_c_idx", bus.c_idx, 0);
        check("rst_c_last", bus.c_last, 0);
      end
      if (hold_prev && !m_rst) begin
        check("hold_data", bus.c_data, hold_d);
        check("hold_idx", bus.c_idx, hold_i);
      end
      if (bus.c_valid && bus.c_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("c_data", bus.c_data, e.d);
          check("c_idx", bus.c_idx, e.idx);
          check("c_last", bus.c_last, e.last);
        end
      end
      hold_prev = bus.c_valid && !bus.c_ready;
      hold_d    = bus.c_data;
      hold_i    = int'(bus.c_idx);
    end else begin
      hold_prev = 0;
    end
    if (to_cnt != to_seen) begin
      check("drain_timeout", to_cnt - to_seen, 0);
      to_seen = to_cnt;
    end
    if (done_req && !done_ack) begin
      check("exp_q_empty", exp_q.size(), 0);
      done_ack = 1;
    end
  end

  // Stimulus
  bit rnd_mode = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_mode) begin
        bus.c_ready = 1'($urandom_range(0, 1));
        bus.clr_ovf = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  task automatic stream(input dat_t v[$]);
    bus.in_strobe = 1'b1;
    foreach (v[k]) begin
      bus.in_data = v[k];
      step(P);
    end
    bus.in_strobe = 1'b0;
    bus.in_data   = '0;
    step(2);
  endtask

  task automatic rand_vals(input int n, output dat_t v[$]);
    logic [31:0] r;
    v.delete();
    for (int i = 0; i < n; i++) begin
      r = $urandom;
      v.push_back(r[DW-1:0]);
    end
  endtask

  task automatic drain();
    int k;
    rnd_mode    = 0;
    bus.c_ready = 1'b1;
    bus.clr_ovf = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || m_full != 0) && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) to_cnt++;
    step(2);
  endtask

  task automatic clear_ovf();
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    step();
  endtask

  initial begin
    dat_t v[$];
    bus.in_data   = '0;
    bus.in_strobe = 1'b0;
    bus.c_ready   = 1'b0;
    bus.clr_ovf   = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);

    // one matrix with extreme values
    bus.c_ready = 1'b1;
    v = '{dat_t'(100), dat_t'(-3), dat_t'(65280), dat_t'(-65536)};
    stream(v);
    drain();

    // backpressure on the first element
    bus.c_ready = 1'b0;
    v = '{dat_t'(100), dat_t'(-3), dat_t'(65280), dat_t'(-65536)};
    stream(v);
    step(10);
    drain();

    // overflow: three matrices into two banks
    bus.c_ready = 1'b0;
    rand_vals(3 * N, v);
    stream(v);
    step(3);
    drain();
    clear_ovf();

    // abort after two captures, then a clean matrix
    bus.c_ready = 1'b1;
    v = '{dat_t'(7), dat_t'(8)};
    stream(v);
    v = '{dat_t'(1), dat_t'(2), dat_t'(3), dat_t'(4)};
    stream(v);
    drain();

    // concurrent fill and drain
    bus.c_ready = 1'b1;
    rand_vals(3 * N, v);
    stream(v);
    drain();

    // reset with one bank full and a partial matrix in flight
    bus.c_ready   = 1'b0;
    rand_vals(N, v);
    stream(v);
    bus.in_strobe = 1'b1;
    bus.in_data   = dat_t'(55);
    step(P);
    bus.in_data   = dat_t'(-55);
    step(P);
    rst           = 1'b1;
    bus.in_strobe = 1'b0;
    step();
    rst = 1'b0;
    step(2);
    rand_vals(N, v);
    stream(v);
    drain();

    // random streams, aborts, backpressure and clears
    for (int it = 0; it < 30; it++) begin
      rnd_mode = 1;
      rand_vals($urandom_range(1, 3 * N), v);
      stream(v);
      step($urandom_range(0, 8));
    end
    drain();
    clear_ovf();

    done_req = 1;
    for (int k = 0; k < 5 && !done_ack; k++) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
